// File: rtl/ctrl_mc.sv
// Multicycle control unit for the SISC core: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// resolves branches against the status register and counts retired instructions.
module ctrl_mc #(
  parameter int OPW  = 4,
  parameter int MMW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [OPW-1:0]  opcode,
  input  logic [MMW-1:0]  mm,
  input  logic [MMW-1:0]  stat,
  input  logic            mem_rdy,
  output logic            mem_req,
  output logic            dm_we,
  output logic            ir_load,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            br_sel,
  output logic            pc_rst,
  output logic            rf_we,
  output logic            wb_sel,
  output logic [1:0]      alu_op,
  output logic            sr_en,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] instret
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [OPW-1:0] OP_NOOP = OPW'(0);
  localparam logic [OPW-1:0] OP_ALU  = OPW'(1);
  localparam logic [OPW-1:0] OP_LOD  = OPW'(2);
  localparam logic [OPW-1:0] OP_STR  = OPW'(3);
  localparam logic [OPW-1:0] OP_BRA  = OPW'(4);
  localparam logic [OPW-1:0] OP_BRR  = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6);
  localparam logic [OPW-1:0] OP_BNR  = OPW'(7);
  localparam logic [OPW-1:0] OP_HLT  = {OPW{1'b1}};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t          state_q, state_d;
  logic [CNTW-1:0] instret_q, instret_d;
  logic            illegal_q, illegal_d;
  logic            stat_hit;
  logic            op_known;
  logic            retire;

  assign illegal = illegal_q;
  assign instret = instret_q;

  // Next-state and control decode; branch resolution reads stat in the same cycle.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    dm_we    = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = 2'b00;
    sr_en    = 1'b0;
    halted   = 1'b0;
    stat_hit = |(stat & mm);
    op_known = (opcode <= OP_BNR) || (opcode == OP_HLT);
    case (state_q)
      S_START: begin
        pc_rst  = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_ALU: begin
            alu_op  = {1'b0, mm[MMW-1]};
            sr_en   = 1'b1;
            state_d = S_WB;
          end
          OP_LOD, OP_STR: begin
            alu_op  = 2'b10;
            state_d = S_MEM;
          end
          OP_BRA, OP_BRR: begin
            pc_write = stat_hit;
            pc_sel   = stat_hit;
            br_sel   = stat_hit && (opcode == OP_BRR);
          end
          OP_BNE, OP_BNR: begin
            pc_write = !stat_hit;
            pc_sel   = !stat_hit;
            br_sel   = !stat_hit && (opcode == OP_BNR);
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        dm_we   = (opcode == OP_STR);
        if (mem_rdy) begin
          state_d = (opcode == OP_LOD) ? S_WB : S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = (opcode == OP_LOD);
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  // Retirement counter and sticky illegal-opcode flag.
  always_comb begin
    retire    = (state_d == S_FETCH) &&
                ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));
    instret_d = instret_q;
    illegal_d = illegal_q;
    if (retire && (instret_q != CNT_MAX)) begin
      instret_d = instret_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
    if ((state_q == S_DECODE) && (state_d == S_EXEC) && !op_known) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q   <= S_START;
      instret_q <= {CNTW{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Self-checking bench for ctrl_mc: instruction-level reference model drives expected
// per-cycle control vectors; a CNTW=3 copy shares the stimulus for saturation checks.
module tb_ctrl_mc;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [3:0]  opcode, mm, stat;
  logic        mem_rdy;

  logic        mem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we, wb_sel, sr_en, halted, illegal;
  logic [1:0]  alu_op;
  logic [15:0] instret;
  logic        mem_req3, dm_we3, ir_load3, pc_write3, pc_sel3, br_sel3, pc_rst3, rf_we3, wb_sel3, sr_en3, halted3, illegal3;
  logic [1:0]  alu_op3;
  logic [2:0]  instret3;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  logic model_ill = 1'b0;

  // Control vector bit positions
  localparam int B_MREQ = 13, B_DMWE = 12, B_IRLD = 11, B_PCW = 10, B_PCSEL = 9, B_BRSEL = 8,
                 B_PCRST = 7, B_RFWE = 6, B_WBSEL = 5, B_ALU1 = 4, B_ALU0 = 3, B_SREN = 2,
                 B_HALT = 1, B_ILL = 0;

  logic [13:0] act, act3;
  assign act  = {mem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we, wb_sel, alu_op, sr_en, halted, illegal};
  assign act3 = {mem_req3, dm_we3, ir_load3, pc_write3, pc_sel3, br_sel3, pc_rst3, rf_we3, wb_sel3, alu_op3, sr_en3, halted3, illegal3};

  ctrl_mc #(.OPW(4), .MMW(4), .CNTW(16)) u_dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .dm_we(dm_we), .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .pc_rst(pc_rst), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
    .sr_en(sr_en), .halted(halted), .illegal(illegal), .instret(instret)
  );

  ctrl_mc #(.OPW(4), .MMW(4), .CNTW(3)) u_sat (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
    .mem_req(mem_req3), .dm_we(dm_we3), .ir_load(ir_load3), .pc_write(pc_write3), .pc_sel(pc_sel3),
    .br_sel(br_sel3), .pc_rst(pc_rst3), .rf_we(rf_we3), .wb_sel(wb_sel3), .alu_op(alu_op3),
    .sr_en(sr_en3), .halted(halted3), .illegal(illegal3), .instret(instret3)
  );

  always #5 clk = ~clk;

  function automatic bit is_defined(input logic [3:0] op);
    return (op <= 4'd7) || (op == 4'hF);
  endfunction

  // Runs one instruction from FETCH; expected per-cycle controls come from instruction-level rules.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                           input int fw, input int mw, input string tag);
    logic [13:0] exp_q[$];
    logic        rdy_q[$];
    logic [3:0]  st_q[$];
    logic [13:0] e;
    logic        ill_after;
    bit          taken;
    ill_after = model_ill | !is_defined(op);
    for (int k = 0; k < fw; k++) begin
      e = '0; e[B_MREQ] = 1'b1; e[B_ILL] = model_ill;
      exp_q.push_back(e); rdy_q.push_back(1'b0); st_q.push_back(4'($urandom));
    end
    e = '0; e[B_MREQ] = 1'b1; e[B_IRLD] = 1'b1; e[B_PCW] = 1'b1; e[B_ILL] = model_ill;
    exp_q.push_back(e); rdy_q.push_back(1'b1); st_q.push_back(4'($urandom));
    e = '0; e[B_ILL] = model_ill;
    exp_q.push_back(e); rdy_q.push_back(1'($urandom)); st_q.push_back(4'($urandom));
    if (op == 4'hF) begin
      e = '0; e[B_HALT] = 1'b1; e[B_ILL] = model_ill;
      exp_q.push_back(e); rdy_q.push_back(1'($urandom)); st_q.push_back(4'($urandom));
    end else begin
      e = '0; e[B_ILL] = ill_after;
      if (op == 4'd1) begin
        e[B_ALU0] = m[3]; e[B_SREN] = 1'b1;
      end else if (op == 4'd2 || op == 4'd3) begin
        e[B_ALU1] = 1'b1;
      end else if (op >= 4'd4 && op <= 4'd7) begin
        taken = (op <= 4'd5) ? ((s & m) != 4'd0) : ((s & m) == 4'd0);
        e[B_PCW] = taken; e[B_PCSEL] = taken;
        e[B_BRSEL] = taken && (op == 4'd5 || op == 4'd7);
      end
      exp_q.push_back(e); rdy_q.push_back(1'($urandom)); st_q.push_back(s);
      if (op == 4'd2 || op == 4'd3) begin
        for (int k = 0; k <= mw; k++) begin
          e = '0; e[B_MREQ] = 1'b1; e[B_DMWE] = (op == 4'd3); e[B_ILL] = ill_after;
          exp_q.push_back(e); rdy_q.push_back(k == mw); st_q.push_back(4'($urandom));
        end
      end
      if (op == 4'd1 || op == 4'd2) begin
        e = '0; e[B_RFWE] = 1'b1; e[B_WBSEL] = (op == 4'd2); e[B_ILL] = ill_after;
        exp_q.push_back(e); rdy_q.push_back(1'($urandom)); st_q.push_back(4'($urandom));
      end
      model_cnt++;
      model_ill = ill_after;
    end
    opcode = op;
    mm = m;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_rdy = rdy_q[i];
      stat = st_q[i];
      #1;
      checks++;
      if (act !== exp_q[i] || act3 !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b / %b want %b", tag, i, act, act3, exp_q[i]);
      end
      @(negedge clk);
    end
    if (op != 4'hF) begin
      #1;
      checks++;
      if (instret !== 16'((model_cnt > 65535) ? 65535 : model_cnt) ||
          instret3 !== 3'((model_cnt > 7) ? 7 : model_cnt)) begin
        errors++;
        $display("FAIL %s instret: got %0d / %0d want count %0d", tag, instret, instret3, model_cnt);
      end
    end
  endtask

  task automatic test_reset();
    rst_f = 1'b1; mem_rdy = 1'b1; opcode = 4'd0; mm = 4'd0; stat = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (act !== 14'b00000010000000 || instret !== 16'd0 || instret3 !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: got %b ir=%0d want 00000010000000 ir=0", act, instret);
    end
    rst_f = 1'b0;
    #1;
    checks++;
    if (act !== 14'b00000010000000) begin
      errors++;
      $display("FAIL reset_start: got %b want 00000010000000", act);
    end
    model_cnt = 0;
    model_ill = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    run_instr(4'd1, 4'b0000, 4'($urandom), 0, 0, "alu_mm0");
    checks++;
    if (instret !== 16'd1) begin
      errors++;
      $display("FAIL alu_instret: got %0d want 1", instret);
    end
    run_instr(4'd1, 4'b1010, 4'($urandom), 1, 0, "alu_imm");
    run_instr(4'd1, 4'($urandom), 4'($urandom), 2, 0, "alu_rand");
  endtask

  task automatic test_mem();
    run_instr(4'd2, 4'($urandom), 4'($urandom), 0, 3, "lod_wait3");
    run_instr(4'd3, 4'($urandom), 4'($urandom), 1, 0, "str");
    run_instr(4'd3, 4'($urandom), 4'($urandom), 0, 2, "str_wait2");
  endtask

  task automatic test_branch();
    run_instr(4'd6, 4'b0010, 4'b0010, 0, 0, "bne_not_taken");
    run_instr(4'd6, 4'b0010, 4'b0000, 0, 0, "bne_taken");
    run_instr(4'd7, 4'b0010, 4'b0000, 0, 0, "bnr_taken");
    run_instr(4'd4, 4'b1000, 4'b1001, 0, 0, "bra_taken");
    run_instr(4'd5, 4'b0100, 4'b0111, 0, 0, "brr_taken");
    run_instr(4'd5, 4'b0100, 4'b1011, 0, 0, "brr_not_taken");
  endtask

  task automatic test_illegal();
    run_instr(4'hA, 4'($urandom), 4'($urandom), 0, 0, "illegal_a");
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set: got %b want 1", illegal);
    end
    run_instr(4'd1, 4'b1000, 4'($urandom), 0, 0, "alu_after_illegal");
    test_reset();
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got %b want 0", illegal);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_instr(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_halt();
    run_instr(4'hF, 4'($urandom), 4'($urandom), 0, 0, "hlt");
    for (int n = 0; n < 20; n++) begin
      mem_rdy = 1'($urandom);
      #1;
      checks++;
      if (act !== {12'b0, 1'b1, model_ill}) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %b want %b", n, act, {12'b0, 1'b1, model_ill});
      end
      @(negedge clk);
    end
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    #1;
    checks++;
    if (act !== 14'b00000010000000) begin
      errors++;
      $display("FAIL halt_reset_start: got %b want 00000010000000", act);
    end
    model_cnt = 0;
    model_ill = 1'b0;
    @(negedge clk);
    mem_rdy = 1'b0;
    #1;
    checks++;
    if (act !== 14'b10000000000000) begin
      errors++;
      $display("FAIL halt_reset_fetch: got %b want 10000000000000", act);
    end
  endtask

  task automatic test_sat();
    test_reset();
    for (int n = 0; n < 9; n++) begin
      run_instr(4'd0, 4'($urandom), 4'($urandom), 0, 0, "noop_sat");
    end
    checks++;
    if (instret3 !== 3'd7 || instret !== 16'd9) begin
      errors++;
      $display("FAIL saturate: got %0d / %0d want 7 / 9", instret3, instret);
    end
    opcode = 4'd2;
    mem_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_rdy = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || dm_we !== 1'b0) begin
      errors++;
      $display("FAIL mem_pending: got req=%b we=%b want req=1 we=0", mem_req, dm_we);
    end
    rst_f = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (act !== 14'b00000010000000 || instret !== 16'd0 || instret3 !== 3'd0) begin
      errors++;
      $display("FAIL reset_in_mem: got %b ir=%0d/%0d want 00000010000000 ir=0/0", act, instret, instret3);
    end
    rst_f = 1'b0;
    model_cnt = 0;
    model_ill = 1'b0;
    @(negedge clk);
    run_instr(4'd1, 4'($urandom), 4'($urandom), 0, 0, "alu_after_reset");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_illegal();
    test_random();
    test_halt();
    test_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
